// File: rtl/sign_mag_accum_pkg.sv
// Shared state encodings and magnitude helper for the sign-magnitude accumulator.
package sign_mag_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest magnitude representable by an n-bit sign-magnitude word.
    function automatic int unsigned mag_max(input int unsigned n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sign_mag_add.sv
// Combinational N-bit sign-magnitude adder.
// Latency: 0 cycles. Backpressure: none (pure combinational).
// Magnitude wraps on overflow; callers widen the operands when that matters.
module sign_mag_add #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    logic         w_sa;
    logic         w_sb;
    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;

    assign w_sa = i_a[N-1];
    assign w_sb = i_b[N-1];
    assign w_ma = i_a[N-2:0];
    assign w_mb = i_b[N-2:0];

    // Unlike signs subtract the smaller magnitude; ties take the sign of i_a.
    always_comb begin
        o_sum = '0;
        if (w_sa == w_sb) begin
            o_sum = {w_sa, w_ma + w_mb};
        end else if (w_ma >= w_mb) begin
            o_sum = {w_sa, w_ma - w_mb};
        end else begin
            o_sum = {w_sb, w_mb - w_ma};
        end
    end

endmodule

// File: rtl/sign_mag_accum.sv
// Framed saturating accumulator of sign-magnitude operands, one result per frame.
// Latency: result valid the cycle after the last input handshake (1 cycle after start if len=0).
// Backpressure: result held in DONE until out_ready; no inputs taken outside ACC.
module sign_mag_accum
    import sign_mag_accum_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [N-2:0] L_MAG_MAX = (N-1)'(mag_max(N));

    state_t           r_state;
    logic [N-1:0]     r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;

    logic [N:0]       w_acc_ext;
    logic [N:0]       w_in_ext;
    logic [N:0]       w_sum;
    logic [N-1:0]     w_next_acc;
    logic             w_next_ovf;

    // One spare magnitude bit keeps the raw sum exact so saturation can be detected.
    assign w_acc_ext = {r_acc[N-1],   1'b0, r_acc[N-2:0]};
    assign w_in_ext  = {in_data[N-1], 1'b0, in_data[N-2:0]};

    sign_mag_add #(
        .N (N + 1)
    ) u_add (
        .i_a   (w_acc_ext),
        .i_b   (w_in_ext),
        .o_sum (w_sum)
    );

    always_comb begin
        w_next_ovf = w_sum[N-1];
        w_next_acc = '0;
        if (w_sum[N-1]) begin
            w_next_acc = {w_sum[N], L_MAG_MAX};
        end else if (w_sum[N-2:0] != '0) begin
            w_next_acc = {w_sum[N], w_sum[N-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_len   <= frame_len;
                        r_state <= (frame_len == '0) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        r_acc <= w_next_acc;
                        r_ovf <= r_ovf | w_next_ovf;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == r_len - CNT_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_sum   = out_valid ? r_acc : '0;
    assign out_ovf   = out_valid & r_ovf;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed-vector bench for sign_mag_accum (N=4, CNT_W=4); inputs driven and outputs sampled on falling edges.
module tb_sign_mag_accum;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] frame_len;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_sum;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sign_mag_accum #(
        .N     (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Starts a frame, streams len operands (low nibble first), optional 2-cycle bubble
    // before operand index bubble_at, then checks the DONE result without handshaking it.
    task automatic run_frame(input string tag, input logic [3:0] len, input logic [15:0] ops,
                             input logic [3:0] exp_sum, input logic exp_ovf, input int bubble_at);
        @(negedge clk);
        check_eq({tag, " idle busy"}, 32'(busy), 32'd0);
        start     = 1'b1;
        frame_len = len;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            if (i == bubble_at) begin
                in_valid = 1'b0;
                in_data  = 4'b0111;
                @(negedge clk);
                @(negedge clk);
            end
            check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
            check_eq({tag, " early valid"}, 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = ops[i*4 +: 4];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, " out_sum"}, 32'(out_sum), 32'(exp_sum));
        check_eq({tag, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check_eq({tag, " in_ready done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, " back idle"}, 32'(busy), 32'd0);
        check_eq({tag, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        frame_len = 4'd0;
        in_data   = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst in_ready", 32'(in_ready), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst out_sum", 32'(out_sum), 32'd0);
        reset = 1'b0;

        // +3 +2 -1 = +4
        run_frame("c1", 4'd3, 16'h0923, 4'b0100, 1'b0, -1);
        drain("c1");
        // +5 +6 saturates to +7
        run_frame("c2a", 4'd2, 16'h0065, 4'b0111, 1'b1, -1);
        drain("c2a");
        // -7 -1 saturates to -7
        run_frame("c2b", 4'd2, 16'h009F, 4'b1111, 1'b1, -1);
        drain("c2b");
        // saturated +7 reused: +7 -1 = +6, overflow stays sticky
        run_frame("c2c", 4'd3, 16'h0965, 4'b0110, 1'b1, -1);
        drain("c2c");
        // +5 -5 and -5 +5 both give +0
        run_frame("c3a", 4'd2, 16'h00D5, 4'b0000, 1'b0, -1);
        drain("c3a");
        run_frame("c3b", 4'd2, 16'h005D, 4'b0000, 1'b0, -1);
        drain("c3b");
        run_frame("c3c", 4'd1, 16'h0008, 4'b0000, 1'b0, -1);
        drain("c3c");

        // Zero-length frame: straight to DONE, nothing accepted
        in_valid = 1'b1;
        in_data  = 4'b0011;
        run_frame("c4", 4'd0, 16'h0000, 4'b0000, 1'b0, -1);
        drain("c4");

        // Bubbles mid-frame, then a held result with ignored start pulses
        run_frame("c5", 4'd3, 16'h0923, 4'b0100, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            start     = k[0];
            frame_len = 4'd5;
            @(negedge clk);
            check_eq("c5 hold valid", 32'(out_valid), 32'd1);
            check_eq("c5 hold sum", 32'(out_sum), 32'b0100);
            check_eq("c5 hold ovf", 32'(out_ovf), 32'd0);
            check_eq("c5 hold in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        drain("c5");
        @(negedge clk);
        check_eq("c5 no restart", 32'(busy), 32'd0);

        // Reset after the second accept of a 3-operand frame
        start     = 1'b1;
        frame_len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 4'b0010;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("c6 rst valid", 32'(out_valid), 32'd0);
        check_eq("c6 rst in_ready", 32'(in_ready), 32'd0);
        check_eq("c6 rst busy", 32'(busy), 32'd0);
        check_eq("c6 rst sum", 32'(out_sum), 32'd0);
        check_eq("c6 rst ovf", 32'(out_ovf), 32'd0);
        run_frame("c6", 4'd1, 16'h000A, 4'b1010, 1'b0, -1);
        drain("c6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
